mem_arbiter2: RTL and testbench
===============================

Name: mem_arbiter2

Overview:
- Two-requester arbiter and sequencer for the single-port, word-wide, synchronous-read program/data memory (rom256/rom512 class: `wen`, word `addr`, `wdata`, `rdata`; 1-cycle read latency).
- Port m0 is the picoRV32 native memory bus; port m1 is the firmware loader/debug bus.
- Converts byte-strobed writes into read-modify-write sequences, because the memory has only a full-word write enable.
- Sits between the core/loader and the memory instance in the picoRV32 SoC top.

Parameters:
- ADDR_W, 9, memory word-address width (8 for a 256-word memory, 9 for 512).
- ROM_WORDS, 256, size of the write-protected region in words; used only with MEM_ARB_ROM_WP_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- m0_valid  in  1  CPU request.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_wstrb  in  4  CPU byte strobes; 0 = read.
- m0_ready  out  1  CPU completion pulse.
- m0_rdata  out  32  CPU read data, valid while m0_ready=1.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for the loader.
- mem_wen  out  1  memory word write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered inside the memory.

Behaviour:
- Protocol (picoRV32 native bus):
  - Master holds valid, addr, wdata and wstrb stable until it samples ready=1.
  - ready is a one-cycle pulse.
  - If valid is still high in the cycle after ready, it is treated as a new request.
- Word address = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias. addr[1:0] is ignored.
- FSM states: IDLE, ACCESS, MERGE_WR, DONE.
  - IDLE: if any valid is high, grant one master; latch its addr, wdata, wstrb and the grant; go to ACCESS.
  - ACCESS: mem_addr = latched word address.
    - wstrb=4'hF: mem_wen=1, mem_wdata=wdata; go to DONE.
    - wstrb=0: read; go to DONE.
    - Otherwise: read; go to MERGE_WR.
  - MERGE_WR: mem_wen=1. mem_wdata byte i = wstrb[i] ? wdata byte i : mem_rdata byte i. Go to DONE.
  - DONE: granted master's ready=1 and rdata=mem_rdata (read-back data for writes, don't-care to master). Go to IDLE.
- Latency, with valid first sampled in IDLE at cycle N:
  - Read or full write: ready at N+2.
  - Partial write: ready at N+3.
  - Back-to-back requests: one transaction per 3 cycles (4 for partial writes).
- Arbitration is 2-way round-robin.
  - last_grant register resets to 1, so m0 wins the first tie.
  - On a tie, the master not granted last wins.
  - A lone requester is always granted.
  - The grant is held for the whole transaction; a request arriving mid-transaction waits for IDLE.
- Non-granted master: ready=0, rdata=0.
- mem_wen, mem_addr and mem_wdata depend only on state and latched registers. There is no combinational path from any m*_valid.
- Reset values (immediate, asynchronous): state=IDLE, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0, latched fields=0.
- Reset mid-transaction aborts the transaction with no ready pulse. If reset arrives in ACCESS or MERGE_WR, mem_wen drops at once; the write completes only if a clock edge occurred before reset asserted.
- Simultaneous valid from both masters in the cycle a transaction ends: the next IDLE applies round-robin, so the other master is served next.

Optional Feature:
- Macro: MEM_ARB_ROM_WP_EN.
- With the macro defined: an m0 write (wstrb≠0) to a word address below ROM_WORDS is discarded.
  - FSM goes IDLE→ACCESS→DONE with mem_wen=0 throughout.
  - m0_ready still pulses at N+2 for full and partial writes alike, so the CPU never hangs.
  - m1 writes and all reads are unaffected.
- Without the macro: no protection; all writes proceed as above.

Decomposition:
- Package mem_arb_pkg:
  - FSM state enum (IDLE, ACCESS, MERGE_WR, DONE).
  - Constants WSTRB_FULL=4'hF and WSTRB_READ=4'h0.
  - Byte-merge function (wstrb, new, old → merged).
- Sub-module mem_arb_rr: 2-way round-robin grant logic, owning the last_grant register, with inputs req[1:0] and advance and output grant. The rest stays in mem_arbiter2.

Test Plan:
- Read: memory preloaded with word 5 = 32'hDEADBEEF; m0 read at addr 0x14 → m0_ready at N+2 with m0_rdata=32'hDEADBEEF; mem_wen never high.
- Full write: m1 writes 32'h12345678 to 0x20 with wstrb 4'hF → mem_wen=1 in ACCESS at word 8; m1_ready at N+2; a later read of 0x20 returns 32'h12345678.
- Partial write: word 8=32'h12345678; m0 writes 32'hAABBCCDD with wstrb 4'b0101 → mem_wen only in MERGE_WR, mem_wdata=32'h12BB56DD; m0_ready at N+3.
- Contention: both valid at reset release → m0 served first, m1 next. Both re-request continuously → strict alternation, no starvation.
- Reset mid-operation: resetn low during MERGE_WR → mem_wen and ready drop immediately; memory word unchanged; the first request after reset completes normally.
- Write protect: with MEM_ARB_ROM_WP_EN, m0 writes 4'hF to word 10 → m0_ready at N+2, mem_wen stays 0, word 10 unchanged; the same write from m1 updates word 10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM states, strobe constants and byte merge for mem_arbiter2
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] WSTRB_FULL = 4'hF;
    localparam logic [3:0] WSTRB_READ = 4'h0;

    function automatic logic [31:0] byte_merge(
        input logic [3:0]  wstrb,
        input logic [31:0] new_data,
        input logic [31:0] old_data
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = wstrb[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - 2-way round-robin grant; o_grant is the winning master index
module mem_arb_rr (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic       o_grant
);

    logic r_last_grant;

    // Resetting last_grant to 1 makes m0 win the first tie.
    always_comb begin
        o_grant = i_req[1];
        if (i_req == 2'b11) begin
            o_grant = ~r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-master arbiter/RMW sequencer for a sync-read word memory; MEM_ARB_ROM_WP_EN drops m0 writes below ROM_WORDS
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int ROM_WORDS = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef MEM_ARB_ROM_WP_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_drop;

    logic [1:0]        w_req;
    logic              w_gnt;
    logic              w_advance;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wstrb;
    logic [ADDR_W-1:0] w_word;
    logic              w_rom_hit;
    logic              w_drop;
    logic              w_done;
    logic [33-ADDR_W:0] w_unused_addr;

    assign w_req     = {m1_valid, m0_valid};
    assign w_advance = (r_state == IDLE) && (w_req != 2'b00);

    mem_arb_rr u_rr (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_grant   (w_gnt)
    );

    assign w_sel_addr    = w_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata   = w_gnt ? m1_wdata : m0_wdata;
    assign w_sel_wstrb   = w_gnt ? m1_wstrb : m0_wstrb;
    assign w_word        = w_sel_addr[ADDR_W+1:2];
    assign w_unused_addr = {w_sel_addr[31:ADDR_W+2], w_sel_addr[1:0]};

    // Protected writes still walk ACCESS->DONE so the CPU always sees ready.
    assign w_rom_hit = !w_gnt && (w_sel_wstrb != WSTRB_READ)
                       && ({{(32-ADDR_W){1'b0}}, w_word} < 32'(ROM_WORDS));
    assign w_drop    = WP_EN & w_rom_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gnt   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_drop  <= 1'b0;
        end else if (w_advance) begin
            r_gnt   <= w_gnt;
            r_addr  <= w_word;
            r_wdata <= w_sel_wdata;
            r_wstrb <= w_sel_wstrb;
            r_drop  <= w_drop;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_wen   = 1'b0;
        mem_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_req != 2'b00) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_drop || r_wstrb == WSTRB_READ) begin
                    w_next = DONE;
                end else if (r_wstrb == WSTRB_FULL) begin
                    mem_wen = 1'b1;
                    w_next  = DONE;
                end else begin
                    w_next = MERGE_WR;
                end
            end
            MERGE_WR: begin
                mem_wen   = 1'b1;
                mem_wdata = byte_merge(r_wstrb, r_wdata, mem_rdata);
                w_next    = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign mem_addr = r_addr;
    assign w_done   = (r_state == DONE);
    assign m0_ready = w_done & ~r_gnt;
    assign m1_ready = w_done & r_gnt;
    assign m0_rdata = m0_ready ? mem_rdata : 32'h0;
    assign m1_rdata = m1_ready ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - randomized self-checking bench for mem_arbiter2 against a transaction-level model
module tb_mem_arbiter2;

    localparam int ADDR_W    = 9;
    localparam int ROM_WORDS = 256;
    localparam int WORDS     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              m0_valid, m1_valid;
    logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]        m0_wstrb, m1_wstrb;
    logic              m0_ready, m1_ready;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic        tb_clear;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter2 #(.ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_valid  (m0_valid),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    endfunction

    // Synchronous-read memory, old data on read-during-write.
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    task automatic drive(input int m, input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    // One isolated transaction from master m; k counts cycles from the first sampled valid.
    task automatic txn(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input string tag);
        int          w, lat, exp_lat, wen_n;
        logic        drop, other;
        logic [31:0] got_rd, wd, exp_rd, exp_wd;
        logic [ADDR_W-1:0] wa;
        w      = int'(addr[ADDR_W+1:2]);
        drop   = 1'b0;
`ifdef MEM_ARB_ROM_WP_EN
        drop   = (m == 0) && (strb != 4'h0) && (w < ROM_WORDS);
`endif
        exp_lat = (strb == 4'h0 || strb == 4'hF || drop) ? 2 : 3;
        exp_rd  = ref_mem[w];
        exp_wd  = model_write(ref_mem[w], wdata, strb);
        lat = -1; wen_n = 0; other = 1'b0; got_rd = '0; wd = '0; wa = '0;
        @(posedge clk); #1;
        drive(m, 1'b1, addr, wdata, strb);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_wen) begin
                wen_n++; wd = mem_wdata; wa = mem_addr;
            end
            other = other | ((m == 0) ? (m1_ready | (m1_rdata != 0)) : (m0_ready | (m0_rdata != 0)));
            if ((m == 0) ? m0_ready : m1_ready) begin
                lat = k; got_rd = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        drive(m, 1'b0, 32'h0, 32'h0, 4'h0);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_other"}, 32'(other), 32'h0);
        if (strb == 4'h0) begin
            check({tag, "_wen_n"}, 32'(wen_n), 32'h0);
            check({tag, "_rdata"}, got_rd, exp_rd);
        end else if (drop) begin
            check({tag, "_wen_n"}, 32'(wen_n), 32'h0);
        end else begin
            check({tag, "_wen_n"}, 32'(wen_n), 32'h1);
            check({tag, "_wdata"}, wd, exp_wd);
            check({tag, "_waddr"}, 32'(wa), 32'(w));
            ref_mem[w] = exp_wd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int w;
        int sel;
        logic [3:0]  s;
        logic [31:0] a;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        resetn   = 1'b0;
        tb_clear = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 tb_clear = 1'b0;

        // Reset state with both requests already pending.
        drive(0, 1'b1, 32'h0000_0004, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0000_0008, 32'h0, 4'h0);
        @(negedge clk);
        check("rst_wen", 32'(mem_wen), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);

        // Contention from reset release: m0 first, then strict alternation every 3 cycles.
        @(posedge clk); #1 resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 30 && seen < 6; k++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                check($sformatf("rr%0d_who", seen), 32'(m1_ready), 32'(seen % 2));
                check($sformatf("rr%0d_cyc", seen), 32'(k), 32'(2 + 3 * seen));
                check($sformatf("rr%0d_both", seen), 32'(m0_ready & m1_ready), 32'h0);
                check($sformatf("rr%0d_rdata", seen), m1_ready ? m1_rdata : m0_rdata,
                      ref_mem[(seen % 2 == 1) ? 2 : 1]);
                seen++;
            end
        end
        check("rr_count", 32'(seen), 32'd6);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Directed read / full write / partial write.
        txn(1, 32'h0000_0014, 32'hDEADBEEF, 4'hF, "pre_w5");
        txn(0, 32'h0000_0014, 32'h0, 4'h0, "rd_w5");
        txn(1, 32'h0000_0020, 32'h12345678, 4'hF, "fw_w8");
        txn(1, 32'h0000_0020, 32'h0, 4'h0, "rd_w8");
        txn(0, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, "pw_w8");
        txn(0, 32'hFFFF_F822, 32'h0, 4'h0, "rd_alias_w8");

        // Reset during MERGE_WR: the write must not land.
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h0000_0020, 32'hCAFEF00D, 4'b0011);
        repeat (3) @(negedge clk);
        check("mid_merge_wen", 32'(mem_wen), 32'h1);
        #1 resetn = 1'b0;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("mid_rst_wen", 32'(mem_wen), 32'h0);
        check("mid_rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        txn(1, 32'h0000_0020, 32'h0, 4'h0, "post_rst_rd");

        // Word 10: protected against m0 when the ROM guard is built in.
        txn(0, 32'h0000_0028, 32'h0BAD_F00D, 4'hF, "wp_m0_w");
        txn(0, 32'h0000_0028, 32'h0, 4'h0, "wp_m0_rd");
        txn(1, 32'h0000_0028, 32'h600D_F00D, 4'hF, "wp_m1_w");
        txn(1, 32'h0000_0028, 32'h0, 4'h0, "wp_m1_rd");

        for (int t = 0; t < 40; t++) begin
            w   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(300, 315);
            a   = ($urandom & 32'hFFFF_F803) | (32'(w) << 2);
            sel = $urandom_range(0, 2);
            s   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
            txn($urandom_range(0, 1), a, $urandom, s, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
